rope_grab_ctrl: RTL and testbench

- Consumes the rope's top-left position (the output of the rope trajectory stage) plus the player's free-motion position and rope-collision flag.
- Attaches Donkey Kong Jr to the rope and carries him with the rope's swing.
- Handles climbing up/down by key, and releases him on jump, with a re-grab cooldown.
- Its outputs feed the player sprite draw stage in place of the free-motion position whenever the player is attached.

---
 rtl/rope_grab_ctrl.sv | 152 +++++++++++++++
 tb/tb_rope_grab_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rope_grab_ctrl.sv
// rope_grab_ctrl
//   Attaches the player to the swinging rope, carries him with the rope,
//   lets him climb while hanging, and releases him on jump. After a release
//   there is a cooldown during which rope contact is ignored, so he does not
//   re-grab the rope he just left.
//
// Ports
//   clk, resetN          system clock, async active-low reset
//   startOfFrame         one-clk pulse per video frame
//   ropeTopLeftX/Y       rope top-left position from the trajectory stage
//   playerInX/Y          free-motion player position
//   ropeCollision        player/rope overlap (level)
//   keyUp/keyDown/keyJump  climb and release keys (level)
//   playerX/Y            position handed to the sprite draw stage
//   attached             player is on the rope
//   atTop/atBottom       player sits at an end of the climbable range
//   releasePulse         one clk when the player lets go
module rope_grab_ctrl #(
  parameter int GRAB_X_OFFSET   = 16,
  parameter int ROPE_LENGTH     = 128,
  parameter int PLAYER_HEIGHT   = 32,
  parameter int CLIMB_STEP      = 2,
  parameter int SETTLE_FRAMES   = 4,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic signed [10:0] ropeTopLeftX,
  input  logic signed [10:0] ropeTopLeftY,
  input  logic signed [10:0] playerInX,
  input  logic signed [10:0] playerInY,
  input  logic               ropeCollision,
  input  logic               keyUp,
  input  logic               keyDown,
  input  logic               keyJump,
  output logic signed [10:0] playerX,
  output logic signed [10:0] playerY,
  output logic               attached,
  output logic               atTop,
  output logic               atBottom,
  output logic               releasePulse
);

  localparam logic [7:0]         MAX_OFF  = 8'(ROPE_LENGTH - PLAYER_HEIGHT);
  localparam logic [7:0]         STEP     = 8'(CLIMB_STEP);
  localparam logic [4:0]         SETTLE_LD = 5'(SETTLE_FRAMES);
  localparam logic [4:0]         COOL_LD  = 5'(COOLDOWN_FRAMES);
  localparam logic signed [10:0] GRAB_X   = 11'(GRAB_X_OFFSET);

  typedef enum logic [1:0] {FREE, SETTLE, HANG, COOLDOWN} state_e;

  state_e             state_q, state_d;
  logic [7:0]         off_q, off_d;
  logic [4:0]         cnt_q, cnt_d;
  logic signed [10:0] px_q, px_d, py_q, py_d;
  logic               att_q, att_d, top_q, top_d, bot_q, bot_d, rel_q, rel_d;

  // Grab offset in 12 bits so any pair of 11-bit positions subtracts exactly.
  logic signed [11:0] grab_diff;
  logic [8:0]         down_sum;

  assign grab_diff = {playerInY[10], playerInY} - {ropeTopLeftY[10], ropeTopLeftY};
  assign down_sum  = {1'b0, off_q} + {1'b0, STEP};

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    rel_d   = 1'b0;
    case (state_q)
      FREE: begin
        if (ropeCollision) begin
          if (grab_diff[11])
            off_d = 8'd0;
          else if (grab_diff > $signed({4'b0, MAX_OFF}))
            off_d = MAX_OFF;
          else
            off_d = grab_diff[7:0];
          cnt_d   = SETTLE_LD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // Keys are ignored here; only frames are counted.
        if (startOfFrame) begin
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_d = HANG;
        end
      end
      HANG: begin
        if (startOfFrame) begin
          if (keyJump) begin
            rel_d   = 1'b1;
            cnt_d   = COOL_LD;
            state_d = COOLDOWN;
          end else if (keyUp && !keyDown) begin
            off_d = (off_q < STEP) ? 8'd0 : off_q - STEP;
          end else if (keyDown && !keyUp) begin
            off_d = (down_sum > {1'b0, MAX_OFF}) ? MAX_OFF : down_sum[7:0];
          end
        end
      end
      COOLDOWN: begin
        if (startOfFrame) begin
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_d = FREE;
        end
      end
      default: state_d = FREE;
    endcase

    // Outputs follow the next state so the draw stage sees the grab at once.
    att_d = (state_d == SETTLE) || (state_d == HANG);
    px_d  = att_d ? ropeTopLeftX + GRAB_X : playerInX;
    py_d  = att_d ? ropeTopLeftY + $signed({3'b0, off_d}) : playerInY;
    top_d = att_d && (off_d == 8'd0);
    bot_d = att_d && (off_d == MAX_OFF);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= FREE;
      off_q   <= 8'd0;
      cnt_q   <= 5'd0;
      px_q    <= '0;
      py_q    <= '0;
      att_q   <= 1'b0;
      top_q   <= 1'b0;
      bot_q   <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      px_q    <= px_d;
      py_q    <= py_d;
      att_q   <= att_d;
      top_q   <= top_d;
      bot_q   <= bot_d;
      rel_q   <= rel_d;
    end
  end

  assign playerX      = px_q;
  assign playerY      = py_q;
  assign attached     = att_q;
  assign atTop        = top_q;
  assign atBottom     = bot_q;
  assign releasePulse = rel_q;

endmodule

// File: tb/tb_rope_grab_ctrl.sv
module tb_rope_grab_ctrl;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic signed [10:0] ropeTopLeftX, ropeTopLeftY, playerInX, playerInY;
  logic               ropeCollision, keyUp, keyDown, keyJump;
  logic signed [10:0] playerX, playerY;
  logic               attached, atTop, atBottom, releasePulse;

  int checks = 0;
  int errors = 0;

  rope_grab_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .ropeTopLeftX(ropeTopLeftX), .ropeTopLeftY(ropeTopLeftY),
    .playerInX(playerInX), .playerInY(playerInY),
    .ropeCollision(ropeCollision), .keyUp(keyUp), .keyDown(keyDown),
    .keyJump(keyJump), .playerX(playerX), .playerY(playerY),
    .attached(attached), .atTop(atTop), .atBottom(atBottom),
    .releasePulse(releasePulse)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 free, 1 settling, 2 hanging, 3 cooling down.
  int         m_mode, m_off, m_left;
  logic [10:0] e_px, e_py;
  logic        e_att, e_top, e_bot, e_rel;

  task automatic model_reset();
    m_mode = 0; m_off = 0; m_left = 0;
    e_px = 0; e_py = 0; e_att = 0; e_top = 0; e_bot = 0; e_rel = 0;
  endtask

  task automatic model_clock();
    int d;
    e_rel = 0;
    if (m_mode == 0) begin
      if (ropeCollision) begin
        d = int'(playerInY) - int'(ropeTopLeftY);
        m_off  = (d < 0) ? 0 : (d > 96) ? 96 : d;
        m_left = 4;
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (startOfFrame) begin
        m_left--;
        if (m_left == 0) m_mode = 2;
      end
    end else if (m_mode == 2) begin
      if (startOfFrame) begin
        if (keyJump) begin
          e_rel = 1; m_left = 15; m_mode = 3;
        end else if (keyUp && !keyDown) m_off = (m_off - 2 < 0) ? 0 : m_off - 2;
        else if (keyDown && !keyUp) m_off = (m_off + 2 > 96) ? 96 : m_off + 2;
      end
    end else begin
      if (startOfFrame) begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
    end
    e_att = (m_mode == 1) || (m_mode == 2);
    e_px  = e_att ? 11'(int'(ropeTopLeftX) + 16) : playerInX;
    e_py  = e_att ? 11'(int'(ropeTopLeftY) + m_off) : playerInY;
    e_top = e_att && (m_off == 0);
    e_bot = e_att && (m_off == 96);
  endtask

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("playerX", playerX, e_px);
    check("playerY", playerY, e_py);
    check("attached", 11'(attached), 11'(e_att));
    check("atTop", 11'(atTop), 11'(e_top));
    check("atBottom", 11'(atBottom), 11'(e_bot));
    check("releasePulse", 11'(releasePulse), 11'(e_rel));
  endtask

  // One clock: model follows the edge, outputs are compared 1 time unit later,
  // and control returns at the falling edge where new inputs are driven.
  task automatic step();
    @(posedge clk);
    if (!resetN) model_reset(); else model_clock();
    #1 compare_all();
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
      for (int c = 0; c < 3; c++) step();
    end
  endtask

  initial begin
    int k;
    resetN = 0; startOfFrame = 0; ropeCollision = 0;
    keyUp = 0; keyDown = 0; keyJump = 0;
    ropeTopLeftX = 280; ropeTopLeftY = 185; playerInX = 50; playerInY = 200;
    model_reset();
    step();
    check("reset_attached", 11'(attached), 11'd0);
    check("reset_playerX", playerX, 11'd0);
    check("reset_playerY", playerY, 11'd0);
    resetN = 1;
    step();

    // Grab at offset 15, keyDown held through the settle frames.
    ropeCollision = 1; keyDown = 1;
    step();
    ropeCollision = 0;
    check("grab_attached", 11'(attached), 11'd1);
    check("grab_playerY", playerY, 11'd200);
    check("grab_playerX", playerX, 11'd296);
    frames(4);
    check("settle_lockout", playerY, 11'd200);
    frames(1);
    check("first_climb", playerY, 11'd202);
    keyDown = 0;

    ropeTopLeftX = 281;
    step();
    check("swing_x", playerX, 11'd297);
    check("swing_y", playerY, 11'd202);

    keyUp = 1;
    frames(7);
    check("climb_to_3", playerY, 11'd188);
    frames(1);
    check("climb_to_1", playerY, 11'd186);
    check("not_top_yet", 11'(atTop), 11'd0);
    frames(2);
    check("top_sat", playerY, 11'd185);
    check("atTop", 11'(atTop), 11'd1);
    keyUp = 0; keyDown = 1;
    frames(48);
    check("bottom_sat", playerY, 11'd281);
    check("atBottom", 11'(atBottom), 11'd1);
    keyUp = 1;
    frames(2);
    check("both_hold", playerY, 11'd281);
    keyUp = 0; keyDown = 0;

    // Release, then hold collision through the cooldown.
    keyJump = 1; startOfFrame = 1; playerInX = 77; playerInY = 150;
    step();
    keyJump = 0; startOfFrame = 0;
    check("release_pulse", 11'(releasePulse), 11'd1);
    check("release_detached", 11'(attached), 11'd0);
    check("release_x", playerX, 11'd77);
    ropeCollision = 1;
    k = 0;
    while (!attached && k < 200) begin
      k++;
      startOfFrame = (k % 4 == 0);
      if (k == 1) begin
        step();
        check("release_one_clk", 11'(releasePulse), 11'd0);
      end else step();
    end
    check("regrab_latency", 11'(k), 11'd61);
    startOfFrame = 0; ropeCollision = 0;
    frames(5);

    // Asynchronous reset while hanging.
    @(posedge clk);
    model_clock();
    #2 resetN = 0;
    model_reset();
    #1;
    check("async_attached", 11'(attached), 11'd0);
    check("async_playerX", playerX, 11'd0);
    check("async_playerY", playerY, 11'd0);
    check("async_flags", {8'd0, atTop, atBottom, releasePulse}, 11'd0);
    @(negedge clk);
    step();
    resetN = 1;
    step();
    check("free_after_reset", 11'(attached), 11'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      resetN        = ($urandom_range(0, 599) != 0);
      startOfFrame  = ($urandom_range(0, 3) == 0);
      ropeCollision = ($urandom_range(0, 5) == 0);
      keyUp         = $urandom_range(0, 1);
      keyDown       = $urandom_range(0, 1);
      keyJump       = ($urandom_range(0, 11) == 0);
      ropeTopLeftX  = 11'($urandom_range(0, 2047));
      ropeTopLeftY  = 11'($urandom_range(0, 2047));
      playerInX     = 11'($urandom_range(0, 2047));
      playerInY     = 11'(int'(ropeTopLeftY) + $urandom_range(0, 200) - 40);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
